// File: rtl/sd_resp_rx.sv
// SD card 48-bit command response receiver.
// Samples cmd_in on bit_en strobes after an arm pulse, hunts for the start bit, shifts the
// frame in MSB-first while running CRC7 over bits 47:8, then holds the decoded fields and
// error flags until the consumer handshakes.
// Optional feature: define SD_RESP_TIMEOUT_EN to add a start-bit timeout (64 samples) and the
// timeout output port.
module sd_resp_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_en,
   input  logic        cmd_in,
   input  logic        arm,
   output logic        busy,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic        crc_err,
   output logic        frame_err
`ifdef SD_RESP_TIMEOUT_EN
   ,
   output logic        timeout
`endif
);

   localparam logic [1:0] StIdle      = 2'd0;
   localparam logic [1:0] StWaitStart = 2'd1;
   localparam logic [1:0] StShift     = 2'd2;
   localparam logic [1:0] StHold      = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // Start bit is always 0 once accepted, so only frame bits 46:0 are stored.
   logic [46:0] frame_q, frame_d;
   logic [6:0]  crc_q, crc_d;
   logic        crc_err_q, crc_err_d;
   logic        frame_err_q, frame_err_d;
`ifdef SD_RESP_TIMEOUT_EN
   logic [6:0]  to_cnt_q, to_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   // One serial CRC7 step, polynomial x^7 + x^3 + 1, MSB first.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = crc[6] ^ b;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // Next-state logic: start hunt, bit shifting, CRC update and flag capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      crc_d       = crc_q;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
`ifdef SD_RESP_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (arm) begin
               state_d = StWaitStart;
               cnt_d   = 6'd0;
               crc_d   = 7'd0;
`ifdef SD_RESP_TIMEOUT_EN
               to_cnt_d = 7'd0;
`endif
            end
         end
         StWaitStart: begin
            if (bit_en) begin
               if (!cmd_in) begin
                  // Start bit (frame bit 47) enters the CRC but is not stored.
                  state_d = StShift;
                  cnt_d   = 6'd46;
                  crc_d   = crc7_step(crc_q, 1'b0);
               end
`ifdef SD_RESP_TIMEOUT_EN
               else begin
                  to_cnt_d = to_cnt_q + 7'd1;
                  if (to_cnt_d == 7'd64) begin
                     state_d   = StIdle;
                     timeout_d = 1'b1;
                  end
               end
`endif
            end
         end
         StShift: begin
            if (bit_en) begin
               frame_d = {frame_q[45:0], cmd_in};
               // CRC covers frame bits 47:8 only.
               if (cnt_q >= 6'd8) begin
                  crc_d = crc7_step(crc_q, cmd_in);
               end
               if (cnt_q == 6'd0) begin
                  state_d     = StHold;
                  crc_err_d   = (crc_q != frame_d[7:1]);
                  frame_err_d = frame_d[46] | ~frame_d[0];
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
         end
         StHold: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 6'd0;
         frame_q     <= 47'd0;
         crc_q       <= 7'd0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         crc_q       <= crc_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef SD_RESP_TIMEOUT_EN
   // Start-bit timeout counter and one-cycle timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q  <= 7'd0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`endif

   assign busy       = (state_q != StIdle);
   assign resp_valid = (state_q == StHold);
   assign resp_index = frame_q[45:40];
   assign resp_arg   = frame_q[39:8];
   assign crc_err    = crc_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Self-checking bench for sd_resp_rx: expected responses are queued as frames are driven and
// compared when resp_valid appears. Build with SD_RESP_TIMEOUT_EN to exercise the timeout.
module tb_sd_resp_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_en;
   logic        cmd_in;
   logic        arm;
   logic        busy;
   logic        resp_valid;
   logic        resp_ready;
   logic [5:0]  resp_index;
   logic [31:0] resp_arg;
   logic        crc_err;
   logic        frame_err;
`ifdef SD_RESP_TIMEOUT_EN
   logic        timeout;
`endif

   sd_resp_rx u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .cmd_in     (cmd_in),
      .arm        (arm),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_index (resp_index),
      .resp_arg   (resp_arg),
      .crc_err    (crc_err),
      .frame_err  (frame_err)
`ifdef SD_RESP_TIMEOUT_EN
      ,
      .timeout    (timeout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic        crc;
      logic        fe;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [47:0] FrameGood = 48'h11_00000900_67;
   localparam logic [47:0] FrameCrc  = 48'h11_00000900_65;
   localparam logic [47:0] FrameEnd0 = 48'h11_00000900_66;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference CRC7 over frame bits 47:8.
   function automatic logic [6:0] ref_crc7(input logic [39:0] bits);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ bits[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   task automatic pulse_arm();
      @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   // Idle-level samples on the CMD line.
   task automatic idle_samples(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cmd_in = 1'b1;
         bit_en = 1'b1;
         @(negedge clk);
         bit_en = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   // Drive the top nbits of f; optionally check resp_valid latency on the end bit.
   task automatic send_frame(input logic [47:0] f, input int nbits, input bit lat_chk);
      for (int i = 47; i >= 48 - nbits; i--) begin
         @(negedge clk);
         cmd_in = f[i];
         bit_en = 1'b1;
         if (i == 0 && lat_chk) begin
            check_eq("valid_before_end", resp_valid, 1'b0);
            @(posedge clk);
            #1;
            check_eq("valid_latency", resp_valid, 1'b1);
         end
         @(negedge clk);
         bit_en = 1'b0;
         cmd_in = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic collect(input string tag, output exp_t got_e);
      exp_t e;
      int   w;
      w = 0;
      got_e = '0;
      while (!resp_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_eq({tag, "_arrive"}, resp_valid, 1'b1);
      check_eq({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
      if (resp_valid && sb_q.size() != 0) begin
         e = sb_q.pop_front();
         got_e = e;
         check_eq({tag, "_index"}, resp_index, e.idx);
         check_eq({tag, "_arg"}, resp_arg, e.arg);
         check_eq({tag, "_crc_err"}, crc_err, e.crc);
         check_eq({tag, "_frame_err"}, frame_err, e.fe);
      end
   endtask

   task automatic handshake(input logic with_arm);
      @(negedge clk);
      resp_ready = 1'b1;
      arm        = with_arm;
      @(posedge clk);
      #1;
      check_eq("hs_busy", busy, 1'b0);
      check_eq("hs_valid", resp_valid, 1'b0);
      @(negedge clk);
      resp_ready = 1'b0;
      arm        = 1'b0;
      @(negedge clk);
      check_eq("hs_arm_ignored", busy, 1'b0);
   endtask

   initial begin
      exp_t        e;
      logic [47:0] fm;
      logic [6:0]  c;
      bit          stable;

      rst_n      = 1'b1;
      bit_en     = 1'b0;
      cmd_in     = 1'b1;
      arm        = 1'b0;
      resp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("reset_outputs", {busy, resp_valid, resp_index, resp_arg, crc_err, frame_err},
               40'd0);
`ifdef SD_RESP_TIMEOUT_EN
      check_eq("reset_timeout", timeout, 1'b0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);

      // Good frame, preceded by a glitch without bit_en and some idle samples.
      pulse_arm();
      check_eq("armed_busy", busy, 1'b1);
      @(negedge clk);
      cmd_in = 1'b0;
      @(negedge clk);
      cmd_in = 1'b1;
      idle_samples(5);
      check_eq("glitch_no_start", resp_valid, 1'b0);
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b0, fe: 1'b0});
      send_frame(FrameGood, 48, 1'b1);
      collect("good", e);
      handshake(1'b0);

      // Corrupted CRC.
      pulse_arm();
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b1, fe: 1'b0});
      send_frame(FrameCrc, 48, 1'b1);
      collect("crc", e);
      handshake(1'b0);

      // End bit 0.
      pulse_arm();
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b0, fe: 1'b1});
      send_frame(FrameEnd0, 48, 1'b1);
      collect("end0", e);
      handshake(1'b0);

      // Different index/arg with a correct CRC built by the reference model.
      fm = {2'b00, 6'h2A, 32'hA5C3_0F96, 8'h00};
      c  = ref_crc7(fm[47:8]);
      fm[7:0] = {c, 1'b1};
      pulse_arm();
      sb_q.push_back('{idx: 6'h2A, arg: 32'hA5C3_0F96, crc: 1'b0, fe: 1'b0});
      send_frame(fm, 48, 1'b1);
      collect("alt", e);
      handshake(1'b0);

      // Backpressure with a stray arm, then arm coinciding with the handshake.
      pulse_arm();
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b0, fe: 1'b0});
      send_frame(FrameGood, 48, 1'b1);
      collect("bp", e);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         arm = (i == 5);
         if (!resp_valid || !busy || resp_index != e.idx || resp_arg != e.arg ||
             crc_err != e.crc || frame_err != e.fe) stable = 1'b0;
      end
      arm = 1'b0;
      check_eq("bp_stable", stable, 1'b1);
      handshake(1'b1);

      // Reset after 20 bits discards the frame; no arm means nothing decodes.
      pulse_arm();
      send_frame(FrameGood, 20, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midreset_outputs",
               {busy, resp_valid, resp_index, resp_arg, crc_err, frame_err}, 40'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_frame(FrameGood, 48, 1'b0);
      check_eq("noarm_busy", {busy, resp_valid}, 2'b00);
      pulse_arm();
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b0, fe: 1'b0});
      send_frame(FrameGood, 48, 1'b1);
      collect("postreset", e);
      handshake(1'b0);

`ifdef SD_RESP_TIMEOUT_EN
      // 64 idle samples after arm: single timeout pulse, back to idle.
      pulse_arm();
      stable = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         cmd_in = 1'b1;
         bit_en = 1'b1;
         @(posedge clk);
         #1;
         if (i < 63) begin
            if (timeout || !busy) stable = 1'b0;
         end else begin
            check_eq("to_pulse", timeout, 1'b1);
            check_eq("to_busy", busy, 1'b0);
            check_eq("to_valid", resp_valid, 1'b0);
         end
         @(negedge clk);
         bit_en = 1'b0;
         repeat (2) @(negedge clk);
      end
      check_eq("to_no_early", stable, 1'b1);
      check_eq("to_single", timeout, 1'b0);
`else
      // Without the timeout, the receiver waits indefinitely for a start bit.
      pulse_arm();
      idle_samples(70);
      check_eq("wait_persist", busy, 1'b1);
      sb_q.push_back('{idx: 6'h11, arg: 32'h0000_0900, crc: 1'b0, fe: 1'b0});
      send_frame(FrameGood, 48, 1'b1);
      collect("persist", e);
      handshake(1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_resp_rx.md
SD_RESP_RX -- requirements
Module: sd_resp_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 bit_en  in  1  one-clk strobe marking the SD clock sampling edge; cmd_in is sampled only when bit_en=1.
REQ-003 cmd_in  in  1  SD CMD line, already synchronised to clk.
REQ-004 arm  in  1  one-clk pulse requesting reception of one 48-bit response; ignored unless state is IDLE.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 resp_valid  out  1  response fields and status flags are valid; held until accepted.
REQ-007 resp_ready  in  1  consumer accepts the response when resp_valid=1 and resp_ready=1 on the same clk edge.
REQ-008 resp_index  out  6  command index field, frame bits 45:40.
REQ-009 resp_arg  out  32  argument/status field, frame bits 39:8.
REQ-010 crc_err  out  1  received CRC7 differs from computed CRC7.
REQ-011 frame_err  out  1  transmission bit was 1 or end bit was 0.
REQ-012 timeout  out  1  one-clk pulse when no start bit arrives in time (present only with SD_RESP_TIMEOUT_EN).

Function
REQ-013 States SHALL be IDLE, WAIT_START, SHIFT and HOLD; IDLE->WAIT_START on arm.
REQ-014 In WAIT_START, a bit_en sample with cmd_in=0 SHALL count as frame bit 47 (start bit) and move to SHIFT with bit counter=46.
REQ-015 In SHIFT, each bit_en sample SHALL be shifted MSB-first into a 48-bit frame register and decrement the counter.
REQ-016 After the sample of bit 0 (end bit), the next clk SHALL enter HOLD with resp_valid=1; resp_valid SHALL therefore rise exactly 1 clk after the end-bit sample.
REQ-017 CRC7 (polynomial x^7+x^3+1, init 0, MSB-first) SHALL be updated serially over frame bits 47:8: fb=crc[6]^bit; crc={crc[5:0],0}^(fb?7'h09:0).
REQ-018 crc_err SHALL equal (computed CRC != frame bits 7:1); frame_err SHALL equal (bit46==1) OR (bit0==0); both flags are reported independently.
REQ-019 In HOLD, resp_index, resp_arg, crc_err and frame_err SHALL stay stable until the handshake; on handshake the block SHALL return to IDLE and deassert resp_valid on the next clk.
REQ-020 arm asserted in any state other than IDLE SHALL be ignored, including arm coinciding with the handshake.
REQ-021 When bit_en=0, no state, counter or CRC change SHALL occur except the HOLD handshake.
REQ-022 A glitch-length low on cmd_in without bit_en SHALL NOT start a frame.

Reset
REQ-023 While rst_n=0: state=IDLE, busy=0, resp_valid=0, resp_index=0, resp_arg=0, crc_err=0, frame_err=0, timeout=0, CRC and counters cleared.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh arm.

Configuration
REQ-025 Macro SD_RESP_TIMEOUT_EN: when defined, a 7-bit counter SHALL count bit_en samples in WAIT_START; on the 64th sample without a start bit, timeout SHALL pulse for 1 clk and the state SHALL return to IDLE with resp_valid unasserted.
REQ-026 Without SD_RESP_TIMEOUT_EN, the timeout port and counter SHALL be absent, and WAIT_START SHALL persist until a start bit or reset.

Verification
REQ-027 Good frame: arm, then feed 48'h11_00000900_67 -> resp_valid 1 clk after the end-bit sample, index=6'h11, arg=32'h00000900, crc_err=0, frame_err=0.
REQ-028 CRC corrupt: feed 48'h11_00000900_65 -> crc_err=1, frame_err=0, same index and arg.
REQ-029 Backpressure: hold resp_ready=0 for 20 clk with a second arm pulse injected -> outputs stable, arm ignored; resp_ready=1 -> IDLE, busy=0 next clk.
REQ-030 Framing: feed 48'h11_00000900_66 (end bit 0) -> frame_err=1, crc_err=0.
REQ-031 Reset mid-frame: assert rst_n=0 after 20 bits -> all outputs 0 immediately; after release, a fresh arm plus the good frame decodes correctly.
REQ-032 With SD_RESP_TIMEOUT_EN: arm with cmd_in held at 1 for 64 bit_en samples -> timeout pulses once, busy=0, no resp_valid.
